srambank_arb2_ctrl: RTL
=======================

# srambank_arb2_ctrl

Two-requester controller for one 256x18 synchronous SRAM bank. It clears the bank after reset, then shares the bank between requester A and requester B under round-robin arbitration, issuing at most one access per cycle. It returns read data with a one-cycle-late valid strobe. It sits between the bank and two client pipelines, for example a fill path and a lookup path.

## Interface
Parameters:
- `ADDR_W`, default 8: bank address width; depth is 2^ADDR_W.
- `DATA_W`, default 18: bank word width.
- `CLEAR_ON_RESET`, default 1: 1 runs the zero-fill sequence after reset; 0 goes straight to ACTIVE.

Ports (A shown; B is identical with suffix `_b`):
- `clk`  in  1  single clock; everything is sampled on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_a`  in  1  requester A wants an access; held stable until `gnt_a`.
- `we_a`  in  1  1 = write, 0 = read.
- `addr_a`  in  ADDR_W  access address.
- `wdata_a`  in  DATA_W  write data.
- `gnt_a`  out  1  request accepted this cycle (combinational).
- `rvalid_a`  out  1  `rdata_a` is valid (one-cycle pulse).
- `rdata_a`  out  DATA_W  read data.
- `init_done`  out  1  high once the clear sequence has finished.
- `bank_addr`  out  ADDR_W  to the bank address input.
- `bank_wd`  out  DATA_W  to the bank write data input.
- `bank_sel`  out  1  bank access enable.
- `bank_read`  out  1  bank read enable.
- `bank_write`  out  1  bank write enable.
- `bank_dout`  in  DATA_W  bank output. It is latched by the bank and updates only on a read edge.

## Operation
- FSM states: CLEAR and ACTIVE.
  - Reset enters CLEAR if `CLEAR_ON_RESET`=1, otherwise ACTIVE.
- CLEAR:
  - An ADDR_W-bit counter starts at 0.
  - Each cycle drives `bank_sel`=1, `bank_write`=1, `bank_wd`=0, `bank_addr`=counter.
  - After the write to address 2^ADDR_W-1, go to ACTIVE. This takes exactly 2^ADDR_W cycles.
  - All grants are 0 in CLEAR.
- ACTIVE: `init_done`=1. Each cycle at most one requester is granted.
  - Only one requester: that one is granted.
  - Both requesting: grant the one that does not hold priority.
  - The priority flop `last_b` records the last granted requester. It toggles only on a grant. Reset value is 1, so A wins the first tie.
- Granted access: bank controls are driven combinationally from the winner's signals in the same cycle.
  - `bank_sel`=1.
  - `bank_write`=we.
  - `bank_read`=!we.
- Read return:
  - A 2-bit pending register records {valid, requester id} of the read granted in the current cycle.
  - The next cycle, that requester's `rvalid` pulses and its `rdata`=`bank_dout`.
  - `rdata_x` holds its last value between pulses.
- No request, or in CLEAR: `bank_read`=0. Outside CLEAR, `bank_write`=0 and `bank_sel`=0 when idle.
- Same-address write and read in consecutive cycles: the read returns the new data, which the bank naturally provides. No forwarding logic.
- Arithmetic: clear counter wraps at 2^ADDR_W. The terminal condition is counter == all-ones; do not use a carry-out.

## Timing
- Reset values:
  - `gnt_a`, `gnt_b`, `rvalid_a`, `rvalid_b`, `bank_sel`, `bank_read`, `bank_write` = 0.
  - `rdata_a`, `rdata_b`, `bank_addr`, `bank_wd` = 0.
  - `init_done` = 0, or 1 one cycle after reset when `CLEAR_ON_RESET`=0.
  - Pending register cleared; `last_b`=1.
- Read latency: grant in cycle N, `rvalid` in cycle N+1.
- Throughput: one access per cycle, with back-to-back reads allowed. Alternating grants under continuous contention.
- Handshake:
  - A request is accepted on a cycle where req && gnt.
  - Requester inputs must be held while req is high and gnt is low.
  - Dropping req before gnt is legal and withdraws the request.
- Reset mid-operation:
  - A pending read is discarded; no `rvalid` follows.
  - A clear in progress restarts from address 0.

## Structure
- Shared package `srambank_pkg`:
  - ADDR_W and DATA_W defaults.
  - FSM state typedef {CLEAR, ACTIVE}.
  - Requester id constants REQ_A=0 and REQ_B=1.
- Sub-module `srambank_rr_arb2`: two-way round-robin arbiter.
  - Inputs: req[1:0], priority flop, clk/reset.
  - Output: one-hot grant.
- Top level holds the FSM, clear counter, pending register and bank mux.

## Test plan
- Reset with `CLEAR_ON_RESET`=1:
  - 256 consecutive writes of 0 to addresses 0..255.
  - `init_done` rises in cycle 257.
  - No grant while req_a=1 throughout.
  - Afterwards, reading any address returns 0.
- A writes 0x2AAAA to 0x10; next cycle A reads 0x10:
  - `gnt_a` on both cycles.
  - `rvalid_a`=1 and `rdata_a`=0x2AAAA one cycle after the read grant.
  - `rvalid_b` stays 0.
- A and B both request continuously for 6 cycles, B reading 0x20, A reading 0x21:
  - Grants run A,B,A,B,A,B.
  - Each `rvalid` lands on the correct port one cycle after its grant.
- Same-cycle contention on the same address, A writing 0x3FFFF and B reading, with `last_b`=1:
  - A is granted first and B the cycle after.
  - B receives 0x3FFFF.
- Reset asserted in the cycle after a B read grant:
  - `rvalid_b` stays 0.
  - All outputs take their reset values.
  - Clear restarts at address 0.
- Requester withdrawal: B raises req then drops it before any grant while A is active.
  - No B access reaches the bank.
  - `last_b` is unchanged by B.

Source files
------------

// File: rtl/srambank_pkg.sv
// rtl/srambank_pkg.sv - shared types and constants for the two-requester SRAM bank controller
package srambank_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 18;

    localparam int REQ_A = 0;
    localparam int REQ_B = 1;

    typedef enum logic {
        CLEAR  = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/srambank_rr_arb2.sv
// rtl/srambank_rr_arb2.sv - two-way round-robin arbiter with one-hot grant
module srambank_rr_arb2
    import srambank_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // last_b set means B won most recently, so A takes the next tie
    logic last_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_b <= 1'b1;
        end else if (|gnt) begin
            last_b <= gnt[REQ_B];
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (req[REQ_A] && (!req[REQ_B] || last_b)) begin
            gnt[REQ_A] = 1'b1;
        end else if (req[REQ_B]) begin
            gnt[REQ_B] = 1'b1;
        end
    end

endmodule

// File: rtl/srambank_arb2_ctrl.sv
// rtl/srambank_arb2_ctrl.sv - zero-fills one SRAM bank after reset, then shares it between two requesters
module srambank_arb2_ctrl
    import srambank_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic              rvalid_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              init_done,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [DATA_W-1:0] bank_wd,
    output logic              bank_sel,
    output logic              bank_read,
    output logic              bank_write,
    input  logic [DATA_W-1:0] bank_dout
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_cnt;
    logic [1:0]        arb_req;
    logic [1:0]        arb_gnt;
    logic              win_b;
    logic              win_we;
    logic              pend_valid;
    logic              pend_id;
    logic [DATA_W-1:0] hold_a;
    logic [DATA_W-1:0] hold_b;

    // Outputs are forced to their idle values while reset is held
    assign arb_req = {req_b, req_a} & {2{(state == ACTIVE) && !reset}};

    srambank_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (arb_req),
        .gnt   (arb_gnt)
    );

    assign gnt_a     = arb_gnt[REQ_A];
    assign gnt_b     = arb_gnt[REQ_B];
    assign win_b     = arb_gnt[REQ_B];
    assign win_we    = win_b ? we_b : we_a;
    assign init_done = !reset && (state == ACTIVE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR_ON_RESET ? CLEAR : ACTIVE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == CLEAR && clr_cnt == '1) begin
            state_next = ACTIVE;
        end
    end

    always_comb begin
        bank_sel   = 1'b0;
        bank_read  = 1'b0;
        bank_write = 1'b0;
        bank_addr  = '0;
        bank_wd    = '0;
        if (!reset) begin
            if (state == CLEAR) begin
                bank_sel   = 1'b1;
                bank_write = 1'b1;
                bank_addr  = clr_cnt;
            end else if (|arb_gnt) begin
                bank_sel   = 1'b1;
                bank_write = win_we;
                bank_read  = !win_we;
                bank_addr  = win_b ? addr_b : addr_a;
                bank_wd    = win_b ? wdata_b : wdata_a;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_id    <= 1'b0;
        end else begin
            pend_valid <= (|arb_gnt) && !win_we;
            pend_id    <= win_b;
        end
    end

    assign rvalid_a = !reset && pend_valid && (pend_id == 1'(REQ_A));
    assign rvalid_b = !reset && pend_valid && (pend_id == 1'(REQ_B));

    // The bank keeps dout until its next read, so capture it on the pulse to hold rdata
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_a <= '0;
            hold_b <= '0;
        end else begin
            if (rvalid_a) hold_a <= bank_dout;
            if (rvalid_b) hold_b <= bank_dout;
        end
    end

    assign rdata_a = reset ? '0 : (rvalid_a ? bank_dout : hold_a);
    assign rdata_b = reset ? '0 : (rvalid_b ? bank_dout : hold_b);

endmodule
